// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Multi-cycle adder that computes a + b + carry_in over WIDTH bits. Each clock
// it adds DIGIT bits, using a small ripple slice and a registered carry. The
// operation takes STEPS = WIDTH/DIGIT cycles. DIGIT must divide WIDTH exactly.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active low
//   in_valid   a, b and carry_in are valid
//   in_ready   block is idle and can accept operands
//   a, b       WIDTH-bit addends
//   carry_in   carry into bit 0
//   out_valid  sum, carry_out and overflow are valid
//   out_ready  consumer accepts the result
//   sum        (a + b + carry_in) mod 2^WIDTH
//   carry_out  unsigned carry out of bit WIDTH-1
//   overflow   two's-complement overflow of the addition
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int STEPS = WIDTH / DIGIT;
  // A single-step adder still needs a 1-bit counter so the port widths stay legal.
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_next;
  logic             carry_r;
  logic             a_msb;
  logic             b_msb;
  logic             ovf_r;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   digit_res;
  logic             last_step;

  assign last_step = (cnt == CW'(STEPS - 1));

  // Ripple slice: low digit of both operands plus the carry from the previous step.
  assign digit_res = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry_r};

  // New digit enters at the top; after STEPS shifts the first digit sits at bit 0.
  // Expressed as a wide shift so DIGIT == WIDTH needs no special case.
  assign sum_next = WIDTH'({digit_res[DIGIT-1:0], sum_r} >> DIGIT);

  // Handshake and result outputs are forced low while reset is asserted.
  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = rst_n && (state == DONE);
  assign sum       = rst_n ? sum_r : '0;
  assign carry_out = rst_n && carry_r;
  assign overflow  = rst_n && ovf_r;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: defaulting every output of a combinational block first guarantees
    // no path leaves it unassigned, so no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // NOTE: the datapath registers are all reset because a reset must abort an
  // operation in flight and present zeros on the result outputs afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      ovf_r   <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_r <= carry_in;
            a_msb   <= a[WIDTH-1];
            b_msb   <= b[WIDTH-1];
            cnt     <= '0;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> DIGIT;
          b_sh    <= b_sh >> DIGIT;
          sum_r   <= sum_next;
          carry_r <= digit_res[DIGIT];
          cnt     <= cnt + CW'(1);
          // The final step produces the sum MSB, so overflow is settled here.
          if (last_step) begin
            ovf_r <= (a_msb == b_msb) && (digit_res[DIGIT-1] != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Self-checking bench for serial_adder. Six instances cover the configurations
// (WIDTH,DIGIT) = (1,1) (8,1) (16,4) (16,16) (8,2) (12,3). They share the clock,
// reset and operand buses; each has its own handshake signals. Expected values
// come from a WIDTH+1-bit reference addition computed in the bench.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  logic        clk;
  logic        rst_n;
  logic [15:0] a_bus;
  logic [15:0] b_bus;
  logic        cin_bus;
  logic [5:0]  iv;
  logic [5:0]  ordy;
  logic [5:0]  ir;
  logic [5:0]  ov;
  logic [5:0]  co;
  logic [5:0]  of;
  logic [0:0]  s0;
  logic [7:0]  s1;
  logic [15:0] s2;
  logic [15:0] s3;
  logic [7:0]  s4;
  logic [11:0] s5;

  int          wid   [6] = '{1, 8, 16, 16, 8, 12};
  int          steps [6] = '{1, 8, 4, 1, 4, 4};
  int          sel;
  logic [15:0] obs_sum;

  int          checks;
  int          errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_adder #(.WIDTH(1),  .DIGIT(1))  u0 (.clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_bus[0:0]),  .b(b_bus[0:0]),  .carry_in(cin_bus), .out_valid(ov[0]), .out_ready(ordy[0]),
    .sum(s0), .carry_out(co[0]), .overflow(of[0]));
  serial_adder #(.WIDTH(8),  .DIGIT(1))  u1 (.clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_bus[7:0]),  .b(b_bus[7:0]),  .carry_in(cin_bus), .out_valid(ov[1]), .out_ready(ordy[1]),
    .sum(s1), .carry_out(co[1]), .overflow(of[1]));
  serial_adder #(.WIDTH(16), .DIGIT(4))  u2 (.clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a_bus[15:0]), .b(b_bus[15:0]), .carry_in(cin_bus), .out_valid(ov[2]), .out_ready(ordy[2]),
    .sum(s2), .carry_out(co[2]), .overflow(of[2]));
  serial_adder #(.WIDTH(16), .DIGIT(16)) u3 (.clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
    .a(a_bus[15:0]), .b(b_bus[15:0]), .carry_in(cin_bus), .out_valid(ov[3]), .out_ready(ordy[3]),
    .sum(s3), .carry_out(co[3]), .overflow(of[3]));
  serial_adder #(.WIDTH(8),  .DIGIT(2))  u4 (.clk(clk), .rst_n(rst_n), .in_valid(iv[4]), .in_ready(ir[4]),
    .a(a_bus[7:0]),  .b(b_bus[7:0]),  .carry_in(cin_bus), .out_valid(ov[4]), .out_ready(ordy[4]),
    .sum(s4), .carry_out(co[4]), .overflow(of[4]));
  serial_adder #(.WIDTH(12), .DIGIT(3))  u5 (.clk(clk), .rst_n(rst_n), .in_valid(iv[5]), .in_ready(ir[5]),
    .a(a_bus[11:0]), .b(b_bus[11:0]), .carry_in(cin_bus), .out_valid(ov[5]), .out_ready(ordy[5]),
    .sum(s5), .carry_out(co[5]), .overflow(of[5]));

  always_comb begin
    obs_sum = '0;
    case (sel)
      0:       obs_sum = 16'(s0);
      1:       obs_sum = 16'(s1);
      2:       obs_sum = s2;
      3:       obs_sum = s3;
      4:       obs_sum = 16'(s4);
      5:       obs_sum = 16'(s5);
      default: obs_sum = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Runs one operation on instance k, starting and ending at a falling edge.
  // gap > 0 holds out_ready low for gap cycles in DONE while offering new,
  // different operands that must be ignored.
  task automatic do_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                       input logic cv, input int gap);
    int          w;
    int          n;
    int          lat;
    logic [15:0] mask;
    logic [16:0] full;
    logic [15:0] es;
    logic        ec;
    logic        eo;
    w    = wid[k];
    sel  = k;
    mask = 16'((17'd1 << w) - 17'd1);
    full = 17'(av & mask) + 17'(bv & mask) + 17'(cv);
    es   = full[15:0] & mask;
    ec   = full[w];
    eo   = (av[w-1] == bv[w-1]) && (es[w-1] != av[w-1]);

    n = 0;
    while (!ir[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(ir[k]), 32'd1);

    a_bus   = av;
    b_bus   = bv;
    cin_bus = cv;
    iv[k]   = 1'b1;
    ordy[k] = (gap == 0);
    @(negedge clk);
    iv[k] = 1'b0;

    lat = 0;
    while (!ov[k] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(steps[k]));
    check("sum", 32'(obs_sum), 32'(es));
    check("carry_out", 32'(co[k]), 32'(ec));
    check("overflow", 32'(of[k]), 32'(eo));

    for (int i = 0; i < gap; i++) begin
      a_bus   = ~av;
      b_bus   = bv ^ 16'h5a5a;
      cin_bus = ~cv;
      iv[k]   = 1'b1;
      @(negedge clk);
      check("stall_valid", 32'(ov[k]), 32'd1);
      check("stall_ready", 32'(ir[k]), 32'd0);
      check("stall_sum", 32'(obs_sum), 32'(es));
      check("stall_cout", 32'(co[k]), 32'(ec));
      check("stall_ovf", 32'(of[k]), 32'(eo));
    end
    iv[k]   = 1'b0;
    ordy[k] = 1'b1;
    @(negedge clk);
    check("valid_drop", 32'(ov[k]), 32'd0);
    check("ready_back", 32'(ir[k]), 32'd1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int hits;
    int ks [3] = '{1, 4, 5};
    checks  = 0;
    errors  = 0;
    sel     = 1;
    rst_n   = 1'b0;
    iv      = '0;
    ordy    = '0;
    a_bus   = '0;
    b_bus   = '0;
    cin_bus = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(ir), 32'd0);
    check("rst_out_valid", 32'(ov), 32'd0);
    check("rst_sum", 32'(obs_sum), 32'd0);
    check("rst_cout_ovf", 32'({co, of}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(ir), 32'h3f);

    // Registered full adder: all eight input combinations.
    for (int v = 0; v < 8; v++) begin
      logic [2:0] bits;
      bits = 3'(v);
      do_op(0, 16'(bits[2]), 16'(bits[1]), bits[0], 0);
    end

    // Directed 8-bit, one bit per cycle.
    do_op(1, 16'h005a, 16'h003c, 1'b0, 0);
    do_op(1, 16'h00ff, 16'h0001, 1'b0, 0);
    do_op(1, 16'h0080, 16'h0080, 1'b0, 0);
    do_op(1, 16'h00ff, 16'h00ff, 1'b1, 0);

    // Carry ripples through every digit, multi-digit and single-step.
    do_op(2, 16'hffff, 16'h0000, 1'b1, 0);
    do_op(3, 16'hffff, 16'h0000, 1'b1, 0);

    // Backpressure: five stalled cycles in DONE.
    do_op(1, 16'h0037, 16'h0049, 1'b1, 5);

    // Reset in the middle of an 8-step add.
    sel     = 1;
    a_bus   = 16'h0033;
    b_bus   = 16'h0044;
    cin_bus = 1'b0;
    ordy[1] = 1'b1;
    iv[1]   = 1'b1;
    @(negedge clk);
    iv[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrun_rst_valid", 32'(ov[1]), 32'd0);
    check("midrun_rst_ready", 32'(ir[1]), 32'd0);
    check("midrun_rst_sum", 32'(obs_sum), 32'd0);
    check("midrun_rst_flags", 32'({co[1], of[1]}), 32'd0);
    rst_n = 1'b1;
    #1;
    check("midrun_ready_after", 32'(ir[1]), 32'd1);
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ov[1]) hits++;
    end
    check("midrun_no_result", 32'(hits), 32'd0);
    do_op(1, 16'h0001, 16'h0001, 1'b0, 0);

    // Random regression with random result backpressure.
    for (int i = 0; i < 3000; i++) begin
      do_op(ks[i % 3], 16'($urandom), 16'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
